// File: rtl/i2c_slave_write_byte_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_slave_write_byte_pkg
//  Purpose  : Shared types and defaults for the I2C slave byte transmitter
//  Revision : 1.0  initial release
// ============================================================================
package i2c_slave_write_byte_pkg;

    // Default number of clk cycles SDA is held after an SCL falling edge
    localparam int unsigned c_DEFAULT_SDA_HOLD_CYCLES = 4;

    // Byte transmitter states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOW  = 3'd1,
        ST_HOLD      = 3'd2,
        ST_WAIT_RISE = 3'd3,
        ST_HIGH      = 3'd4,
        ST_ACK_HOLD  = 3'd5,
        ST_ACK_RISE  = 3'd6,
        ST_ACK_HIGH  = 3'd7
    } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_slave_write_byte_if.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_slave_write_byte_if
//  Purpose  : Control handshake and pad signals of the slave byte transmitter
//  Revision : 1.0  initial release
// ============================================================================
interface i2c_slave_write_byte_if;
    logic       byte_write_en;
    logic [7:0] byte_write_i;
    logic       byte_write_busy;
    logic       byte_write_ack_o;
    logic       byte_write_finish;
    logic       byte_write_err;
    logic       scl_i;
    logic       sda_i;
    logic       sda_o;

    // Transaction FSM / pad side
    modport master (
        output byte_write_en, byte_write_i, scl_i, sda_i,
        input  byte_write_busy, byte_write_ack_o, byte_write_finish,
               byte_write_err, sda_o
    );

    // Byte transmitter side
    modport slave (
        input  byte_write_en, byte_write_i, scl_i, sda_i,
        output byte_write_busy, byte_write_ack_o, byte_write_finish,
               byte_write_err, sda_o
    );
endinterface
`default_nettype wire

// File: rtl/i2c_slave_write_byte_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_slave_write_byte_edge_detect
//  Purpose  : SCL rise/fall and SDA change detection from last-value registers
//  Revision : 1.0  initial release
// ============================================================================
module i2c_slave_write_byte_edge_detect (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_scl,
    input  wire logic i_sda,
    output logic      o_scl_fall,
    output logic      o_scl_rise,
    output logic      o_sda_chg
);
    logic r_scl_last;
    logic r_sda_last;

    // Track previous SCL/SDA levels; idle bus level is high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_last <= 1'b1;
            r_sda_last <= 1'b1;
        end else begin
            r_scl_last <= i_scl;
            r_sda_last <= i_sda;
        end
    end

    assign o_scl_fall = r_scl_last & ~i_scl;
    assign o_scl_rise = ~r_scl_last & i_scl;
    assign o_sda_chg  = r_sda_last ^ i_sda;
endmodule
`default_nettype wire

// File: rtl/i2c_slave_write_byte.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_slave_write_byte
//  Purpose  : Slave-side I2C byte transmitter, MSB first, samples master ACK
//  Revision : 1.0  initial release
// ============================================================================
module i2c_slave_write_byte
    import i2c_slave_write_byte_pkg::*;
#(
    parameter int unsigned SDA_HOLD_CYCLES = c_DEFAULT_SDA_HOLD_CYCLES
) (
    input wire logic              clk,
    input wire logic              rst,
    i2c_slave_write_byte_if.slave bus
);
    localparam int unsigned HW = $clog2(SDA_HOLD_CYCLES + 1);
    localparam logic [HW-1:0] c_HOLD_LAST = HW'(SDA_HOLD_CYCLES - 1);

    wr_state_t   r_state;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_cnt;
    logic [HW-1:0] r_hold_cnt;
    logic        r_sda_o;
    logic        r_busy;
    logic        r_ack;
    logic        r_finish;
    logic        r_err;

    logic w_scl_fall;
    logic w_scl_rise;
    logic w_sda_chg;

    i2c_slave_write_byte_edge_detect u_edge (
        .clk        (clk),
        .rst        (rst),
        .i_scl      (bus.scl_i),
        .i_sda      (bus.sda_i),
        .o_scl_fall (w_scl_fall),
        .o_scl_rise (w_scl_rise),
        .o_sda_chg  (w_sda_chg)
    );

    // Transmit FSM: all outputs registered; dropping enable aborts silently
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= 8'h00;
            r_bit_cnt  <= 3'd0;
            r_hold_cnt <= '0;
            r_sda_o    <= 1'b1;
            r_busy     <= 1'b0;
            r_ack      <= 1'b0;
            r_finish   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_finish <= 1'b0;
            r_err    <= 1'b0;
            if (r_state != ST_IDLE && !bus.byte_write_en) begin
                // Abort takes priority over any SCL event in the same cycle
                r_state <= ST_IDLE;
                r_sda_o <= 1'b1;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_sda_o <= 1'b1;
                        if (bus.byte_write_en) begin
                            r_shift    <= bus.byte_write_i;
                            r_bit_cnt  <= 3'd7;
                            r_hold_cnt <= '0;
                            r_busy     <= 1'b1;
                            r_state    <= bus.scl_i ? ST_WAIT_LOW : ST_HOLD;
                        end
                    end
                    ST_WAIT_LOW: begin
                        if (w_scl_fall) begin
                            r_hold_cnt <= '0;
                            r_state    <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (w_scl_rise) begin
                            // Master clocked before the hold time elapsed
                            r_sda_o <= r_shift[7];
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else if (r_hold_cnt == c_HOLD_LAST) begin
                            r_sda_o <= r_shift[7];
                            r_state <= ST_WAIT_RISE;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + HW'(1);
                        end
                    end
                    ST_WAIT_RISE: begin
                        if (w_scl_rise)
                            r_state <= ST_HIGH;
                    end
                    ST_HIGH: begin
                        if (w_scl_fall) begin
                            r_hold_cnt <= '0;
                            if (r_bit_cnt == 3'd0) begin
                                r_state <= ST_ACK_HOLD;
                            end else begin
                                r_bit_cnt <= r_bit_cnt - 3'd1;
                                r_shift   <= {r_shift[6:0], 1'b0};
                                r_state   <= ST_HOLD;
                            end
                        end else if ((r_sda_o && !bus.sda_i) || w_sda_chg) begin
                            // Lost arbitration or START/STOP inside the byte
                            r_err   <= 1'b1;
                            r_sda_o <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_ACK_HOLD: begin
                        if (r_hold_cnt == c_HOLD_LAST) begin
                            r_sda_o <= 1'b1;
                            r_state <= ST_ACK_RISE;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + HW'(1);
                        end
                    end
                    ST_ACK_RISE: begin
                        if (w_scl_rise) begin
                            r_ack   <= ~bus.sda_i;
                            r_state <= ST_ACK_HIGH;
                        end
                    end
                    ST_ACK_HIGH: begin
                        if (w_scl_fall) begin
                            r_finish <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= ST_IDLE;
                        end else if (w_sda_chg) begin
                            r_err   <= 1'b1;
                            r_sda_o <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_sda_o <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.sda_o             = r_sda_o;
    assign bus.byte_write_busy   = r_busy;
    assign bus.byte_write_ack_o  = r_ack;
    assign bus.byte_write_finish = r_finish;
    assign bus.byte_write_err    = r_err;
endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_write_byte.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_slave_write_byte
//  Purpose  : Self-checking bench for the I2C slave byte transmitter
//  Revision : 1.0  initial release
// ============================================================================
module tb_i2c_slave_write_byte;
    localparam int HOLD   = 4;
    localparam int LOW_T  = 10;
    localparam int HIGH_T = 8;

    // Expected-output events: kind 0=sda_o 1=busy 2=ack 3=finish pulse 4=err pulse
    typedef struct {
        int   c;
        int   k;
        logic v;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_sda = 1'b1;
    always #5 clk = ~clk;

    i2c_slave_write_byte_if bus();
    assign bus.sda_i = bus.sda_o & m_sda;

    i2c_slave_write_byte #(.SDA_HOLD_CYCLES(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   fin_cnt = 0;
    int   err_cnt = 0;
    bit   chk_en = 1'b0;
    logic e_sda  = 1'b1;
    logic e_busy = 1'b0;
    logic e_ack  = 1'b0;
    logic e_fin, e_err;
    ev_t  evq[$];
    ev_t  keep[$];
    logic [7:0] rbits;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    endtask

    function automatic void sched(input int c, input int k, input logic v);
        ev_t e;
        e.c = c; e.k = k; e.v = v;
        evq.push_back(e);
    endfunction

    // Per-cycle comparison of every output against the event timeline
    always @(negedge clk) begin
        if (chk_en) begin
            e_fin = 1'b0;
            e_err = 1'b0;
            keep  = {};
            foreach (evq[i]) begin
                if (evq[i].c <= cyc) begin
                    case (evq[i].k)
                        0: e_sda  = evq[i].v;
                        1: e_busy = evq[i].v;
                        2: e_ack  = evq[i].v;
                        3: e_fin  = (evq[i].c == cyc);
                        default: e_err = (evq[i].c == cyc);
                    endcase
                end else begin
                    keep.push_back(evq[i]);
                end
            end
            evq = keep;
            check("sda_o",  {31'd0, bus.sda_o},             {31'd0, e_sda});
            check("busy",   {31'd0, bus.byte_write_busy},   {31'd0, e_busy});
            check("ack_o",  {31'd0, bus.byte_write_ack_o},  {31'd0, e_ack});
            check("finish", {31'd0, bus.byte_write_finish}, {31'd0, e_fin});
            check("err",    {31'd0, bus.byte_write_err},    {31'd0, e_err});
            if (bus.byte_write_finish === 1'b1) fin_cnt++;
            if (bus.byte_write_err === 1'b1) err_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One byte as driven by the master. err_bit: bit whose SCL-high phase gets
    // a foreign pull-down. abort_bit: bit after whose high phase SCL falls
    // together with enable dropping.
    task automatic xfer(input logic [7:0] b, input bit en_high, input int err_bit,
                        input int abort_bit, input bit mack);
        bit first_done;
        first_done = 1'b0;
        rbits = 8'h00;
        bus.scl_i = 1'b1;
        tick(3);
        if (en_high) begin
            bus.byte_write_en = 1'b1; bus.byte_write_i = b;
            sched(cyc + 1, 1, 1'b1);
            tick(3);
        end else begin
            bus.scl_i = 1'b0;
            tick(2);
            bus.byte_write_en = 1'b1; bus.byte_write_i = b;
            sched(cyc + 1, 1, 1'b1);
            sched(cyc + 5, 0, b[7]);
            tick(LOW_T - 2);
            first_done = 1'b1;
        end
        for (int i = 7; i >= 0; i--) begin
            if (!(i == 7 && first_done)) begin
                bus.scl_i = 1'b0;
                sched(cyc + 1 + HOLD, 0, b[i]);
                tick(LOW_T);
            end
            bus.scl_i = 1'b1;
            rbits = {rbits[6:0], bus.sda_o};
            if (i == err_bit) begin
                tick(2);
                m_sda = 1'b0;
                sched(cyc + 1, 4, 1'b1);
                sched(cyc + 1, 0, 1'b1);
                sched(cyc + 1, 1, 1'b0);
                tick(1);
                bus.byte_write_en = 1'b0;
                tick(2);
                m_sda = 1'b1;
                tick(3);
                return;
            end
            tick(HIGH_T);
            if (i == abort_bit) begin
                bus.scl_i = 1'b0;
                bus.byte_write_en = 1'b0;
                sched(cyc + 1, 0, 1'b1);
                sched(cyc + 1, 1, 1'b0);
                tick(3);
                bus.scl_i = 1'b1;
                tick(2);
                return;
            end
        end
        // ACK slot
        bus.scl_i = 1'b0;
        sched(cyc + 1 + HOLD, 0, 1'b1);
        tick(6);
        m_sda = !mack;
        tick(LOW_T - 6);
        bus.scl_i = 1'b1;
        sched(cyc + 1, 2, mack);
        tick(HIGH_T);
        bus.scl_i = 1'b0;
        sched(cyc + 1, 3, 1'b1);
        sched(cyc + 1, 1, 1'b0);
        tick(1);
        bus.byte_write_en = 1'b0;
        tick(2);
        m_sda = 1'b1;
        tick(2);
        bus.scl_i = 1'b1;
        tick(2);
    endtask

    int f0, e0;

    initial begin
        bus.byte_write_en = 1'b0;
        bus.byte_write_i  = 8'h00;
        bus.scl_i         = 1'b1;
        tick(3);
        chk_en = 1'b1;
        check("reset sda_o", {31'd0, bus.sda_o}, 32'd1);
        check("reset busy",  {31'd0, bus.byte_write_busy}, 32'd0);
        rst = 1'b0;
        tick(2);

        // 0xA5, en 2 clk after fall, ACK
        f0 = fin_cnt; e0 = err_cnt;
        xfer(8'hA5, 1'b0, -1, -1, 1'b1);
        check("A5 bits", {24'd0, rbits}, 32'hA5);
        check("A5 ack", {31'd0, bus.byte_write_ack_o}, 32'd1);
        check("A5 finish count", fin_cnt - f0, 32'd1);
        check("A5 err count", err_cnt - e0, 32'd0);

        // 0x3C, NACK
        f0 = fin_cnt; e0 = err_cnt;
        xfer(8'h3C, 1'b0, -1, -1, 1'b0);
        check("3C bits", {24'd0, rbits}, 32'h3C);
        check("3C ack", {31'd0, bus.byte_write_ack_o}, 32'd0);
        check("3C finish count", fin_cnt - f0, 32'd1);

        // 0xFF, foreign pull-down in 3rd high phase
        f0 = fin_cnt; e0 = err_cnt;
        xfer(8'hFF, 1'b0, 5, -1, 1'b1);
        check("FF err count", err_cnt - e0, 32'd1);
        check("FF finish count", fin_cnt - f0, 32'd0);
        check("FF busy", {31'd0, bus.byte_write_busy}, 32'd0);

        // 0x00, abort after 4th bit, then 0x81
        f0 = fin_cnt; e0 = err_cnt;
        xfer(8'h00, 1'b0, -1, 4, 1'b1);
        check("00 abort finish", fin_cnt - f0, 32'd0);
        check("00 abort err", err_cnt - e0, 32'd0);
        check("00 abort sda", {31'd0, bus.sda_o}, 32'd1);
        f0 = fin_cnt;
        xfer(8'h81, 1'b0, -1, -1, 1'b1);
        check("81 bits", {24'd0, rbits}, 32'h81);
        check("81 finish count", fin_cnt - f0, 32'd1);

        // 0x5A, enable asserted while SCL high
        f0 = fin_cnt;
        xfer(8'h5A, 1'b1, -1, -1, 1'b1);
        check("5A bits", {24'd0, rbits}, 32'h5A);
        check("5A ack", {31'd0, bus.byte_write_ack_o}, 32'd1);
        check("5A finish count", fin_cnt - f0, 32'd1);

        // Reset mid-byte while SDA is driven low
        bus.scl_i = 1'b1;
        tick(3);
        bus.scl_i = 1'b0;
        tick(2);
        bus.byte_write_en = 1'b1; bus.byte_write_i = 8'h00;
        sched(cyc + 1, 1, 1'b1);
        sched(cyc + 5, 0, 1'b0);
        tick(7);
        check("pre-reset sda_o", {31'd0, bus.sda_o}, 32'd0);
        rst = 1'b1;
        sched(cyc + 1, 0, 1'b1);
        sched(cyc + 1, 1, 1'b0);
        sched(cyc + 1, 2, 1'b0);
        tick(1);
        check("mid reset sda_o", {31'd0, bus.sda_o}, 32'd1);
        check("mid reset ack", {31'd0, bus.byte_write_ack_o}, 32'd0);
        check("mid reset busy", {31'd0, bus.byte_write_busy}, 32'd0);
        rst = 1'b0;
        bus.byte_write_en = 1'b0;
        tick(2);
        bus.scl_i = 1'b1;
        tick(4);
        check("event queue drained", evq.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
